// File: rtl/mmu_pkg.sv
// Shared MMU types and constants: sequencer state encoding, multi-step shift, default widths.
package mmu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } seq_state_t;

    // Multi-step mode works on count>>MM_SHIFT for both termination and address offset.
    localparam int MM_SHIFT     = 2;
    localparam int DIM_ADDR_DEF = 12;
    localparam int DIM_STEP_DEF = 3;

endpackage

// File: rtl/mmu_addr_seq_if.sv
// Descriptor start handshake plus address beat valid/ready bus of the MMU address sequencer.
interface mmu_addr_seq_if
    import mmu_pkg::*;
#(
    parameter int DIM_ADDR = DIM_ADDR_DEF,
    parameter int DIM_STEP = DIM_STEP_DEF
);
    logic                start;
    logic                start_ready;
    logic [DIM_ADDR-1:0] base;
    logic [DIM_ADDR-1:0] target;
    logic [DIM_STEP-1:0] step;
    logic                mm_ss;
    logic                addr_valid;
    logic                addr_ready;
    logic [DIM_ADDR-1:0] addr;
    logic                last;
    logic                busy;
    logic                done;

    modport slave (
        input  start, base, target, step, mm_ss, addr_ready,
        output start_ready, addr_valid, addr, last, busy, done
    );

    modport master (
        output start, base, target, step, mm_ss, addr_ready,
        input  start_ready, addr_valid, addr, last, busy, done
    );
endinterface

// File: rtl/mmu_step_cnt.sv
// Stepped beat counter with clear/enable; flags the final beat via a mode-dependent >= compare.
module mmu_step_cnt
    import mmu_pkg::*;
#(
    parameter int DIM_ADDR = DIM_ADDR_DEF,
    parameter int DIM_STEP = DIM_STEP_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic [DIM_STEP-1:0] step,
    input  logic                mm,
    input  logic [DIM_ADDR-1:0] target,
    output logic [DIM_ADDR-1:0] cnt,
    output logic                last
);
    logic [DIM_ADDR-1:0] cnt_reg;
    logic [DIM_ADDR:0]   cnt_next_wide;
    logic [DIM_ADDR:0]   cmp;

    // One extra bit keeps the carry so a count near the top cannot wrap past target.
    assign cnt_next_wide = {1'b0, cnt_reg} + {{(DIM_ADDR + 1 - DIM_STEP){1'b0}}, step};
    assign cmp           = mm ? (cnt_next_wide >> MM_SHIFT) : cnt_next_wide;
    assign last          = (cmp >= {1'b0, target});
    assign cnt           = cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_next_wide[DIM_ADDR-1:0];
        end
    end

endmodule

// File: rtl/mmu_addr_seq.sv
// Descriptor-driven MMU address sequencer: one address beat per counter step until the target is met.
// Optional abort input enabled by defining MMU_ADDR_SEQ_ABORT_EN.
module mmu_addr_seq
    import mmu_pkg::*;
#(
    parameter int DIM_ADDR = DIM_ADDR_DEF,
    parameter int DIM_STEP = DIM_STEP_DEF
) (
    input  logic           clk,
    input  logic           rst,
`ifdef MMU_ADDR_SEQ_ABORT_EN
    input  logic           abort,
`endif
    mmu_addr_seq_if.slave  bus
);
    seq_state_t          state_reg, state_next;
    logic [DIM_ADDR-1:0] base_reg;
    logic [DIM_ADDR-1:0] target_reg;
    logic [DIM_STEP-1:0] step_reg;
    logic                mm_reg;

    logic                accept;
    logic                beat_fire;
    logic                abort_hit;
    logic                cnt_last;
    logic [DIM_ADDR-1:0] cnt;
    logic [DIM_ADDR-1:0] offset;

`ifdef MMU_ADDR_SEQ_ABORT_EN
    assign abort_hit = abort && (state_reg != S_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign accept    = bus.start && (state_reg == S_IDLE);
    assign beat_fire = (state_reg == S_RUN) && bus.addr_ready;

    mmu_step_cnt #(
        .DIM_ADDR (DIM_ADDR),
        .DIM_STEP (DIM_STEP)
    ) u_step_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (beat_fire && !cnt_last && !abort_hit),
        .step   (step_reg),
        .mm     (mm_reg),
        .target (target_reg),
        .cnt    (cnt),
        .last   (cnt_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= S_IDLE;
            base_reg   <= '0;
            target_reg <= '0;
            step_reg   <= '0;
            mm_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                base_reg   <= bus.base;
                target_reg <= bus.target;
                // A zero step would never advance, so it is promoted to one.
                step_reg   <= (bus.step == '0) ? DIM_STEP'(1) : bus.step;
                mm_reg     <= bus.mm_ss;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept) state_next = S_RUN;
            S_RUN:   if (beat_fire && cnt_last) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (abort_hit) state_next = S_IDLE;
    end

    // Outputs depend only on registered state, never on addr_ready.
    assign offset          = mm_reg ? (cnt >> MM_SHIFT) : cnt;
    assign bus.addr        = base_reg + offset;
    assign bus.addr_valid  = (state_reg == S_RUN);
    assign bus.last        = cnt_last && (state_reg == S_RUN);
    assign bus.busy        = (state_reg == S_RUN) || (state_reg == S_DONE);
    assign bus.done        = (state_reg == S_DONE);
    assign bus.start_ready = (state_reg == S_IDLE);

endmodule

// File: tb/tb_mmu_addr_seq.sv
// Directed self-checking bench for mmu_addr_seq; abort scenario runs when MMU_ADDR_SEQ_ABORT_EN is defined.
module tb_mmu_addr_seq;
    localparam int DA = 12;
    localparam int DS = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

`ifdef MMU_ADDR_SEQ_ABORT_EN
    logic abort = 1'b0;
`endif

    mmu_addr_seq_if #(.DIM_ADDR(DA), .DIM_STEP(DS)) bus ();

    mmu_addr_seq #(.DIM_ADDR(DA), .DIM_STEP(DS)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef MMU_ADDR_SEQ_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [DA-1:0] hs_addr[$];
    logic          hs_last[$];
    logic [DA-1:0] vld_addr[$];
    int            done_cyc;

    // Present a descriptor for one cycle; with hold, start stays high carrying a decoy descriptor.
    task automatic start_desc(input logic [DA-1:0] b, input logic [DA-1:0] t,
                              input logic [DS-1:0] s, input logic m, input bit hold);
        bus.base   = b;
        bus.target = t;
        bus.step   = s;
        bus.mm_ss  = m;
        bus.start  = 1'b1;
        @(negedge clk);
        if (hold) begin
            bus.base   = 12'h7FF;
            bus.target = 12'd1;
            bus.step   = 3'd1;
            bus.mm_ss  = 1'b0;
        end else begin
            bus.start = 1'b0;
        end
    endtask

    // Drive addr_ready and record beats until done appears or the cycle budget runs out.
    task automatic collect(input int budget, input bit toggle);
        hs_addr.delete();
        hs_last.delete();
        vld_addr.delete();
        done_cyc = -1;
        for (int c = 0; c < budget; c++) begin
            bus.addr_ready = toggle ? (c % 2 == 0) : 1'b1;
            if (bus.addr_valid) vld_addr.push_back(bus.addr);
            if (bus.addr_valid && bus.addr_ready) begin
                hs_addr.push_back(bus.addr);
                hs_last.push_back(bus.last);
                $display("  beat: addr=%03h last=%0b", bus.addr, bus.last);
            end
            if (bus.done) begin
                done_cyc = c;
                break;
            end
            @(negedge clk);
        end
        bus.addr_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready: got %b want 1", bus.start_ready); end
        checks++; if (bus.addr_valid !== 1'b0) begin errors++; $display("FAIL reset_addr_valid: got %b want 0", bus.addr_valid); end
        checks++; if (bus.addr !== 12'h000) begin errors++; $display("FAIL reset_addr: got %h want 000", bus.addr); end
        checks++; if (bus.last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", bus.last); end
        checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done: got %b want 00", {bus.busy, bus.done}); end
    endtask

    task automatic test_ss_stream();
        logic [DA-1:0] ea[$];
        logic          el[$];
        ea = '{12'h100, 12'h102, 12'h104, 12'h106};
        el = '{1'b0, 1'b0, 1'b0, 1'b1};
        $display("test_ss_stream");
        start_desc(12'h100, 12'd8, 3'd2, 1'b0, 1'b0);
        checks++; if (bus.addr_valid !== 1'b1) begin errors++; $display("FAIL ss_first_valid: got %b want 1", bus.addr_valid); end
        collect(20, 1'b0);
        checks++;
        if (hs_addr.size() != ea.size()) begin errors++; $display("FAIL ss_beats: got %0d want %0d", hs_addr.size(), ea.size()); end
        else for (int i = 0; i < ea.size(); i++) begin
            checks++;
            if (hs_addr[i] !== ea[i] || hs_last[i] !== el[i]) begin
                errors++; $display("FAIL ss_beat%0d: got %h/%b want %h/%b", i, hs_addr[i], hs_last[i], ea[i], el[i]);
            end
        end
        checks++; if (done_cyc != 4) begin errors++; $display("FAIL ss_done_cycle: got %0d want 4", done_cyc); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ss_busy_in_done: got %b want 1", bus.busy); end
        @(negedge clk);
        checks++; if ({bus.done, bus.start_ready} !== 2'b01) begin errors++; $display("FAIL ss_after_done: got done/ready %b want 01", {bus.done, bus.start_ready}); end
    endtask

    task automatic test_mm_mode();
        logic [DA-1:0] ea[$];
        logic          el[$];
        ea = '{12'h020, 12'h021};
        el = '{1'b0, 1'b1};
        $display("test_mm_mode");
        start_desc(12'h020, 12'd2, 3'd4, 1'b1, 1'b0);
        collect(20, 1'b0);
        checks++;
        if (hs_addr.size() != ea.size()) begin errors++; $display("FAIL mm_beats: got %0d want %0d", hs_addr.size(), ea.size()); end
        else for (int i = 0; i < ea.size(); i++) begin
            checks++;
            if (hs_addr[i] !== ea[i] || hs_last[i] !== el[i]) begin
                errors++; $display("FAIL mm_beat%0d: got %h/%b want %h/%b", i, hs_addr[i], hs_last[i], ea[i], el[i]);
            end
        end
        checks++; if (done_cyc != 2) begin errors++; $display("FAIL mm_done_cycle: got %0d want 2", done_cyc); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [DA-1:0] ea[$];
        logic          el[$];
        logic [DA-1:0] ev[$];
        ea = '{12'h000, 12'h002, 12'h004};
        el = '{1'b0, 1'b0, 1'b1};
        ev = '{12'h000, 12'h002, 12'h002, 12'h004, 12'h004};
        $display("test_backpressure");
        start_desc(12'h000, 12'd5, 3'd2, 1'b0, 1'b0);
        collect(20, 1'b1);
        checks++;
        if (hs_addr.size() != ea.size()) begin errors++; $display("FAIL bp_handshakes: got %0d want %0d", hs_addr.size(), ea.size()); end
        else for (int i = 0; i < ea.size(); i++) begin
            checks++;
            if (hs_addr[i] !== ea[i] || hs_last[i] !== el[i]) begin
                errors++; $display("FAIL bp_beat%0d: got %h/%b want %h/%b", i, hs_addr[i], hs_last[i], ea[i], el[i]);
            end
        end
        checks++;
        if (vld_addr.size() != ev.size()) begin errors++; $display("FAIL bp_valid_cycles: got %0d want %0d", vld_addr.size(), ev.size()); end
        else for (int i = 0; i < ev.size(); i++) begin
            checks++;
            if (vld_addr[i] !== ev[i]) begin errors++; $display("FAIL bp_hold%0d: got %h want %h", i, vld_addr[i], ev[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_target_zero();
        $display("test_target_zero");
        start_desc(12'h345, 12'd0, 3'd3, 1'b0, 1'b0);
        collect(10, 1'b0);
        checks++;
        if (hs_addr.size() != 1) begin errors++; $display("FAIL t0_beats: got %0d want 1", hs_addr.size()); end
        else if (hs_addr[0] !== 12'h345 || hs_last[0] !== 1'b1) begin
            errors++; $display("FAIL t0_beat: got %h/%b want 345/1", hs_addr[0], hs_last[0]);
        end
        @(negedge clk);
    endtask

    // Also holds start high with a decoy descriptor to confirm it is ignored outside IDLE.
    task automatic test_step_zero();
        logic [DA-1:0] ea[$];
        logic          el[$];
        ea = '{12'h010, 12'h011, 12'h012};
        el = '{1'b0, 1'b0, 1'b1};
        $display("test_step_zero");
        start_desc(12'h010, 12'd3, 3'd0, 1'b0, 1'b1);
        collect(20, 1'b0);
        bus.start = 1'b0;
        checks++;
        if (hs_addr.size() != ea.size()) begin errors++; $display("FAIL s0_beats: got %0d want %0d", hs_addr.size(), ea.size()); end
        else for (int i = 0; i < ea.size(); i++) begin
            checks++;
            if (hs_addr[i] !== ea[i] || hs_last[i] !== el[i]) begin
                errors++; $display("FAIL s0_beat%0d: got %h/%b want %h/%b", i, hs_addr[i], hs_last[i], ea[i], el[i]);
            end
        end
        @(negedge clk);
        checks++; if ({bus.start_ready, bus.addr_valid} !== 2'b10) begin errors++; $display("FAIL s0_idle_after: got %b want 10", {bus.start_ready, bus.addr_valid}); end
    endtask

    task automatic test_wrap();
        logic [DA-1:0] ea[$];
        ea = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        $display("test_wrap");
        start_desc(12'hFFE, 12'd4, 3'd1, 1'b0, 1'b0);
        collect(20, 1'b0);
        checks++;
        if (hs_addr.size() != ea.size()) begin errors++; $display("FAIL wrap_beats: got %0d want %0d", hs_addr.size(), ea.size()); end
        else for (int i = 0; i < ea.size(); i++) begin
            checks++;
            if (hs_addr[i] !== ea[i]) begin errors++; $display("FAIL wrap_beat%0d: got %h want %h", i, hs_addr[i], ea[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        $display("test_back_to_back");
        start_desc(12'h200, 12'd2, 3'd1, 1'b0, 1'b0);
        collect(20, 1'b0);
        checks++; if (done_cyc != 2) begin errors++; $display("FAIL b2b_first_done: got %0d want 2", done_cyc); end
        @(negedge clk);
        checks++; if (bus.start_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", bus.start_ready); end
        start_desc(12'h300, 12'd1, 3'd1, 1'b0, 1'b0);
        collect(20, 1'b0);
        checks++;
        if (hs_addr.size() != 1 || hs_addr[0] !== 12'h300) begin
            errors++; $display("FAIL b2b_second: got %0d beats first %h want 1 beat 300", hs_addr.size(), (hs_addr.size() > 0) ? hs_addr[0] : 12'hxxx);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        $display("test_reset_mid");
        start_desc(12'h100, 12'd8, 3'd2, 1'b0, 1'b0);
        bus.addr_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.addr_valid !== 1'b1 || bus.addr !== 12'h102) begin errors++; $display("FAIL rm_beat2: got %b/%h want 1/102", bus.addr_valid, bus.addr); end
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.addr_valid !== 1'b0) begin errors++; $display("FAIL rm_async_valid: got %b want 0", bus.addr_valid); end
        checks++; if ({bus.start_ready, bus.busy} !== 2'b10) begin errors++; $display("FAIL rm_async_idle: got %b want 10", {bus.start_ready, bus.busy}); end
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        rst = 1'b1;
        bus.addr_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rm_no_done: got %b want 0", saw_done); end
        checks++; if ({bus.start_ready, bus.addr_valid} !== 2'b10) begin errors++; $display("FAIL rm_after_release: got %b want 10", {bus.start_ready, bus.addr_valid}); end
    endtask

`ifdef MMU_ADDR_SEQ_ABORT_EN
    task automatic test_abort();
        $display("test_abort");
        start_desc(12'h040, 12'd2, 3'd1, 1'b0, 1'b0);
        bus.addr_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.last !== 1'b1 || bus.addr !== 12'h041) begin errors++; $display("FAIL ab_last_beat: got %b/%h want 1/041", bus.last, bus.addr); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        bus.addr_ready = 1'b0;
        checks++; if ({bus.addr_valid, bus.done, bus.start_ready} !== 3'b001) begin errors++; $display("FAIL ab_idle: got valid/done/ready %b want 001", {bus.addr_valid, bus.done, bus.start_ready}); end
        start_desc(12'h080, 12'd0, 3'd1, 1'b0, 1'b0);
        collect(10, 1'b0);
        checks++;
        if (hs_addr.size() != 1 || hs_addr[0] !== 12'h080 || done_cyc != 1) begin
            errors++; $display("FAIL ab_restart: got %0d beats done_cyc %0d want 1 beat at 080 done_cyc 1", hs_addr.size(), done_cyc);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        bus.start      = 1'b0;
        bus.base       = '0;
        bus.target     = '0;
        bus.step       = '0;
        bus.mm_ss      = 1'b0;
        bus.addr_ready = 1'b0;
        @(negedge clk);
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_ss_stream();
        test_mm_mode();
        test_backpressure();
        test_target_zero();
        test_step_zero();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
`ifdef MMU_ADDR_SEQ_ABORT_EN
        test_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
